// File: rtl/seg2bcd_scan_capture.sv
// Purpose : decodes a multiplexed active-low 7-segment bus back to BCD and assembles whole display frames.
// Latency : a seg_in change reaches the work registers after 2 + STABLE_CYCLES + 1 cycles; the frame follows one cycle after the last digit.
// Backpressure: a presented frame stays frozen until frame_ready; scanning continues meanwhile, and the next frame is snapshot after the handshake.
// Ports   : s00_axi_aclk/s00_axi_aresetn clock and async active-low reset; an_in/seg_in observed display bus;
//           err_clr clears the sticky err_out; frame_valid/frame_ready handshake for frame_bcd/frame_blank.
module seg2bcd_scan_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 5
) (
  input  logic                    s00_axi_aclk,
  input  logic                    s00_axi_aresetn,
  input  logic [NUM_DIGITS-1:0]   an_in,
  input  logic [6:0]              seg_in,
  input  logic                    err_clr,
  input  logic                    frame_ready,
  output logic                    frame_valid,
  output logic [4*NUM_DIGITS-1:0] frame_bcd,
  output logic [NUM_DIGITS-1:0]   frame_blank,
  output logic                    err_out
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic {S_COLLECT = 1'b0, S_PRESENT = 1'b1} state_t;

  // Reset bridge: assert immediately, release two clocks after aresetn rises.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) r_rst_sync <= 2'b00;
    else                  r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  logic [NUM_DIGITS-1:0]   r_an_s1, r_an_s2, r_an_prev;
  logic [6:0]              r_seg_s1, r_seg_s2, r_seg_prev;
  logic [CNT_W-1:0]        r_cnt;
  logic [4*NUM_DIGITS-1:0] r_work_bcd, r_frame_bcd;
  logic [NUM_DIGITS-1:0]   r_work_blank, r_frame_blank, r_seen;
  logic                    r_err;
  state_t                  r_state, w_state_nxt;

  logic [NUM_DIGITS-1:0]   w_an_act, w_seen_set;
  logic                    w_an_ok, w_same, w_cap, w_cap_ok, w_cap_bad, w_load;
  logic [IW-1:0]           w_idx;
  logic [3:0]              w_dec_bcd;
  logic                    w_dec_blank, w_dec_ok;

  // Exactly one anode low is a valid digit slot; anything else (blanked scan,
  // overlap during anode switching) holds the dwell counter at zero.
  assign w_an_act = ~r_an_s2;
  assign w_an_ok  = $onehot(w_an_act);
  assign w_same   = (r_an_s2 == r_an_prev) && (r_seg_s2 == r_seg_prev);

  // Fires only on the increment into STABLE_CYCLES, so a long dwell captures once.
  assign w_cap     = w_an_ok && w_same && (r_cnt == CNT_W'(STABLE_CYCLES - 1));
  assign w_cap_ok  = w_cap && w_dec_ok;
  assign w_cap_bad = w_cap && !w_dec_ok;

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_an_act[i]) w_idx = IW'(i);
    end
  end

  assign w_seen_set = {{(NUM_DIGITS-1){1'b0}}, w_cap_ok} << w_idx;

  always_comb begin
    w_dec_bcd   = 4'd0;
    w_dec_blank = 1'b0;
    w_dec_ok    = 1'b1;
    case (r_seg_s2)
      7'h01:   w_dec_bcd = 4'd0;
      7'h4F:   w_dec_bcd = 4'd1;
      7'h12:   w_dec_bcd = 4'd2;
      7'h06:   w_dec_bcd = 4'd3;
      7'h4C:   w_dec_bcd = 4'd4;
      7'h24:   w_dec_bcd = 4'd5;
      7'h20:   w_dec_bcd = 4'd6;
      7'h0F:   w_dec_bcd = 4'd7;
      7'h00:   w_dec_bcd = 4'd8;
      7'h04:   w_dec_bcd = 4'd9;
      7'h7F:   w_dec_blank = 1'b1;
      default: w_dec_ok = 1'b0;
    endcase
  end

  // Input synchroniser and dwell counter.
  always_ff @(posedge s00_axi_aclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_an_s1    <= '0;
      r_an_s2    <= '0;
      r_an_prev  <= '0;
      r_seg_s1   <= '0;
      r_seg_s2   <= '0;
      r_seg_prev <= '0;
      r_cnt      <= '0;
    end else begin
      r_an_s1    <= an_in;
      r_an_s2    <= r_an_s1;
      r_an_prev  <= r_an_s2;
      r_seg_s1   <= seg_in;
      r_seg_s2   <= r_seg_s1;
      r_seg_prev <= r_seg_s2;
      if (!w_an_ok || !w_same)                   r_cnt <= '0;
      else if (r_cnt != CNT_W'(STABLE_CYCLES))   r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Work registers, seen mask and sticky error. A capture landing in the
  // snapshot cycle belongs to the next frame, so its seen bit survives the clear.
  always_ff @(posedge s00_axi_aclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_work_bcd   <= '0;
      r_work_blank <= '0;
      r_seen       <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_cap_ok) begin
        r_work_bcd[{w_idx, 2'b00} +: 4] <= w_dec_bcd;
        r_work_blank[w_idx]             <= w_dec_blank;
      end
      r_seen <= (w_load ? '0 : r_seen) | w_seen_set;
      if (w_cap_bad)    r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= S_COLLECT;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_COLLECT: begin
        if (&r_seen) begin
          w_load      = 1'b1;
          w_state_nxt = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (frame_ready) w_state_nxt = S_COLLECT;
      end
      default: w_state_nxt = S_COLLECT;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_frame_bcd   <= '0;
      r_frame_blank <= '0;
    end else if (w_load) begin
      r_frame_bcd   <= r_work_bcd;
      r_frame_blank <= r_work_blank;
    end
  end

  assign frame_valid = (r_state == S_PRESENT);
  assign frame_bcd   = r_frame_bcd;
  assign frame_blank = r_frame_blank;
  assign err_out     = r_err;

endmodule

// File: tb/tb_seg2bcd_scan_capture.sv
// Purpose : directed plus randomized bench for seg2bcd_scan_capture against a digit-level reference model.
// Latency : frames are compared in order on every handshake; err_out is compared at the end of every dwell.
// Backpressure: frame_ready is held low in one section to exercise frame hold and deferred snapshot.
module tb_seg2bcd_scan_capture;
  localparam int ND = 4;
  localparam int SC = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        clr;
  logic        rdy;
  logic        fv;
  logic [15:0] fb;
  logic [3:0]  fbl;
  logic        err;

  always #5 clk = ~clk;

  seg2bcd_scan_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC), .CNT_W(5)) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .an_in           (an),
    .seg_in          (seg),
    .err_clr         (clr),
    .frame_ready     (rdy),
    .frame_valid     (fv),
    .frame_bcd       (fb),
    .frame_blank     (fbl),
    .err_out         (err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [6:0]  codes [10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};
  int          m_bcd   [ND];
  bit          m_blank [ND];
  bit          m_seen  [ND];
  bit          exp_err;
  logic [19:0] exp_q [$];   // {blank[3:0], bcd[15:0]}
  logic [10:0] last_pat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // 0..9 digit, 10 blank, -1 illegal
  function automatic int decode(input logic [6:0] s);
    if (s == 7'h7F) return 10;
    for (int d = 0; d < 10; d++) if (codes[d] == s) return d;
    return -1;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ND; i++) begin
      m_bcd[i] = 0; m_blank[i] = 1'b0; m_seen[i] = 1'b0;
    end
    exp_err = 1'b0;
  endfunction

  // A dwell is captured once if it outlasts the sync + stability window.
  function automatic void model_dwell(input logic [3:0] a, input logic [6:0] s, input int len);
    int lows = 0;
    int idx  = 0;
    int d;
    bit full = 1'b1;
    logic [19:0] f;
    if (len < SC + 1) return;
    for (int i = 0; i < ND; i++) if (!a[i]) begin lows++; idx = i; end
    if (lows != 1) return;
    d = decode(s);
    if (d < 0) begin exp_err = 1'b1; return; end
    m_bcd[idx]   = (d == 10) ? 0 : d;
    m_blank[idx] = (d == 10);
    m_seen[idx]  = 1'b1;
    for (int i = 0; i < ND; i++) if (!m_seen[i]) full = 1'b0;
    if (full) begin
      f = '0;
      for (int i = 0; i < ND; i++) begin
        f[4*i +: 4] = 4'(m_bcd[i]);
        f[16+i]     = m_blank[i];
        m_seen[i]   = 1'b0;
      end
      exp_q.push_back(f);
    end
  endfunction

  task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int len);
    an = a; seg = s; last_pat = {a, s};
    model_dwell(a, s, len);
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic digit(input int i, input int d);
    logic [3:0] a;
    a = 4'b1111;
    a[i] = 1'b0;
    dwell(a, codes[d], 20);
  endtask

  task automatic pulse_clr();
    clr = 1'b1; exp_err = 1'b0;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame scoreboard: every accepted frame must be the next one the model produced.
  always @(negedge clk) begin
    if (fv && rdy) begin
      chk("frame_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        logic [19:0] e;
        e = exp_q.pop_front();
        chk("frame_bcd", 32'(fb), 32'(e[15:0]));
        chk("frame_blank", 32'(fbl), 32'(e[19:16]));
      end
    end
  end

  initial begin
    rst_n = 1'b0; an = '0; seg = '0; clr = 1'b0; rdy = 1'b1;
    model_reset();
    // Reset held while the bus toggles.
    repeat (8) begin
      @(posedge clk); #1;
      an = 4'($urandom); seg = 7'($urandom);
    end
    @(negedge clk);
    chk("rst_valid", 32'(fv), 32'd0);
    chk("rst_bcd", 32'(fb), 32'd0);
    chk("rst_blank", 32'(fbl), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    an = 4'hF; seg = 7'h7F; last_pat = {an, seg};
    rst_n = 1'b1;
    wait_cyc(4);

    // Single captures, a too-short glitch, then completion.
    digit(0, 3);
    digit(3, 2);
    dwell(4'b1101, 7'h4F, SC - 2);
    digit(2, 5);
    chk("no_frame_partial", 32'(fv), 32'd0);
    digit(1, 9);
    wait_cyc(3);
    chk("frame_2593", 32'(fb), 32'h2593);
    chk("valid_dropped_1", 32'(fv), 32'd0);
    chk("err_clean", 32'(err), 32'd0);

    // Plain scan with consumer always ready.
    digit(0, 1); digit(1, 2); digit(2, 3); digit(3, 4);
    wait_cyc(3);
    chk("frame_4321", 32'(fb), 32'h4321);
    chk("valid_dropped_2", 32'(fv), 32'd0);

    // Backpressure: second frame completes while first is unacknowledged.
    rdy = 1'b0;
    digit(0, 5); digit(1, 6); digit(2, 7); digit(3, 8);
    wait_cyc(3);
    chk("bp_valid", 32'(fv), 32'd1);
    chk("bp_frame_8765", 32'(fb), 32'h8765);
    digit(0, 1); digit(1, 2); digit(2, 3); digit(3, 4);
    chk("bp_hold_valid", 32'(fv), 32'd1);
    chk("bp_hold_8765", 32'(fb), 32'h8765);
    rdy = 1'b1;
    @(posedge clk); #1;
    rdy = 1'b0;
    wait_cyc(3);
    chk("bp_next_valid", 32'(fv), 32'd1);
    chk("bp_next_4321", 32'(fb), 32'h4321);
    rdy = 1'b1;
    wait_cyc(3);
    chk("bp_drained", 32'(fv), 32'd0);

    // Illegal pattern leaves digit 2 untouched and sets the sticky error.
    digit(2, 5);
    dwell(4'b1011, 7'h7E, 20);
    chk("err_set", 32'(err), 32'd1);
    digit(0, 7); digit(1, 8); digit(3, 9);
    wait_cyc(3);
    chk("frame_9587", 32'(fb), 32'h9587);
    chk("err_still_set", 32'(err), 32'd1);
    pulse_clr();
    chk("err_cleared", 32'(err), 32'd0);
    dwell(4'b1011, 7'h7F, 20);
    // Illegal capture in the same cycle as err_clr: the error wins.
    an = 4'b1101; seg = 7'h7E; last_pat = {an, seg};
    repeat (18) @(posedge clk);
    #1; clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
    exp_err = 1'b1;
    wait_cyc(3);
    chk("err_clr_collide", 32'(err), 32'd1);
    pulse_clr();
    chk("err_cleared_2", 32'(err), 32'd0);
    digit(0, 7); digit(1, 8); digit(3, 9);
    wait_cyc(3);
    chk("blank_frame_bcd", 32'(fb), 32'h9087);
    chk("blank_frame_mask", 32'(fbl), 32'h4);

    // Reset mid-frame discards the partial frame.
    digit(0, 1); digit(1, 2);
    rst_n = 1'b0; an = 4'hF; seg = 7'h7F; last_pat = {an, seg};
    #1;
    chk("midrst_bcd", 32'(fb), 32'd0);
    chk("midrst_blank", 32'(fbl), 32'd0);
    wait_cyc(3);
    model_reset();
    rst_n = 1'b1;
    wait_cyc(4);
    digit(2, 3); digit(3, 4);
    chk("midrst_no_frame", 32'(fv), 32'd0);
    digit(0, 5); digit(1, 6);
    wait_cyc(3);
    chk("midrst_frame_4365", 32'(fb), 32'h4365);

    // Randomized dwells: mixed legal/blank/illegal codes, bad anodes, glitches.
    for (int n = 0; n < 70; n++) begin
      logic [3:0] a;
      logic [6:0] s;
      int k, len;
      do begin
        k = $urandom_range(0, 9);
        a = 4'b1111;
        a[$urandom_range(0, 3)] = 1'b0;
        if (k == 0) a = 4'($urandom);
        if (k == 1)      s = 7'($urandom);
        else if (k == 2) s = 7'h7F;
        else             s = codes[$urandom_range(0, 9)];
      end while ({a, s} == last_pat);
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 13) : $urandom_range(20, 40);
      if ($urandom_range(0, 7) == 0) pulse_clr();
      dwell(a, s, len);
      chk("rand_err", 32'(err), 32'(exp_err));
    end

    wait_cyc(40);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
